// File: rtl/vga_ctrl_pkg.sv
// Shared encodings and default geometry for the VGA text-screen blit controller.
package vga_ctrl_pkg;

  localparam logic [11:0] DEF_BASE = 12'h000;
  localparam int unsigned DEF_COLS = 32;
  localparam int unsigned DEF_ROWS = 16;

  typedef enum logic [1:0] {
    OP_CLEAR    = 2'b00,
    OP_SCROLL   = 2'b01,
    OP_FILL_ROW = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_DONE
  } state_e;

endpackage

// File: rtl/vga_port_mux.sv
// Video RAM port-A selector: the CPU wins whenever cpu_en is high, otherwise the engine drives.
module vga_port_mux (
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [11:0] cpu_a,
  input  logic [7:0]  cpu_din,
  input  logic        eng_we,
  input  logic [11:0] eng_a,
  input  logic [7:0]  eng_d,
  input  logic [7:0]  ram_q,
  output logic [11:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_d,
  output logic [7:0]  cpu_dout
);

  assign ram_a    = cpu_en ? cpu_a   : eng_a;
  assign ram_we   = cpu_en ? cpu_we  : eng_we;
  assign ram_d    = cpu_en ? cpu_din : eng_d;
  assign cpu_dout = ram_q;

endmodule

// File: rtl/vga_blit_ctrl.sv
// Text-screen blit engine (clear / scroll-up / fill-row) sharing video RAM port A with the CPU.
module vga_blit_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter logic [11:0] BASE = DEF_BASE,
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [11:0] cpu_a,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_fill,
  input  logic [3:0]  cmd_row,
  output logic        busy,
  output logic        done,
  output logic [11:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_d,
  input  logic [7:0]  ram_q
);

  localparam logic [11:0] COLS_W      = 12'(COLS);
  localparam logic [11:0] SCREEN_LAST = 12'(COLS * ROWS - 1);
  localparam logic [11:0] SCROLL_LAST = 12'(COLS * (ROWS - 1) - 1);
  localparam logic [11:0] LAST_ROW    = 12'(COLS * (ROWS - 1));

  state_e      state, state_nx;
  logic [11:0] idx, idx_nx;
  logic [11:0] fill_end, fill_end_nx;
  logic [7:0]  fill_r, fill_nx;
  logic [7:0]  hold;
  logic        rd_pend;
  logic        grant;
  logic [11:0] eng_a;
  logic        eng_we;
  logic [7:0]  eng_d;

  assign grant     = !cpu_en;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      fill_end <= '0;
      fill_r   <= '0;
      hold     <= '0;
      rd_pend  <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      fill_end <= fill_end_nx;
      fill_r   <= fill_nx;
      rd_pend  <= (state == S_RD) && grant;
      if (rd_pend) hold <= ram_q;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    fill_end_nx = fill_end;
    fill_nx     = fill_r;
    eng_a       = BASE + idx;
    eng_we      = 1'b0;
    eng_d       = fill_r;
    done        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          fill_nx = cmd_fill;
          idx_nx  = '0;
          case (op_e'(cmd_op))
            OP_CLEAR: begin
              fill_end_nx = SCREEN_LAST;
              state_nx    = S_FILL;
            end
            OP_SCROLL: state_nx = S_RD;
            OP_FILL_ROW: begin
              if (32'(cmd_row) < ROWS) begin
                idx_nx      = 12'(cmd_row) * COLS_W;
                fill_end_nx = idx_nx + COLS_W - 12'd1;
                state_nx    = S_FILL;
              end else begin
                state_nx = S_DONE;
              end
            end
            default: state_nx = S_DONE;
          endcase
        end
      end
      S_RD: begin
        eng_a = BASE + idx + COLS_W;
        if (grant) state_nx = S_WR;
      end
      S_WR: begin
        eng_we = 1'b1;
        // ram_q is still live when WR directly follows RD; after a stall it sits in hold.
        eng_d  = rd_pend ? ram_q : hold;
        if (grant) begin
          if (idx == SCROLL_LAST) begin
            idx_nx      = LAST_ROW;
            fill_end_nx = SCREEN_LAST;
            state_nx    = S_FILL;
          end else begin
            idx_nx   = idx + 12'd1;
            state_nx = S_RD;
          end
        end
      end
      S_FILL: begin
        eng_we = 1'b1;
        if (grant) begin
          if (idx == fill_end) state_nx = S_DONE;
          else                 idx_nx   = idx + 12'd1;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  vga_port_mux u_mux (
    .cpu_en   (cpu_en),
    .cpu_we   (cpu_we),
    .cpu_a    (cpu_a),
    .cpu_din  (cpu_din),
    .eng_we   (eng_we),
    .eng_a    (eng_a),
    .eng_d    (eng_d),
    .ram_q    (ram_q),
    .ram_a    (ram_a),
    .ram_we   (ram_we),
    .ram_d    (ram_d),
    .cpu_dout (cpu_dout)
  );

endmodule

// File: doc/vga_blit_ctrl.md
VGA_BLIT_CTRL -- requirements
Module: vga_blit_ctrl

Interface
REQ-001 Parameter BASE, 12'h000, first video RAM address of text screen.
REQ-002 Parameter COLS, 32, characters per row.
REQ-003 Parameter ROWS, 16, rows per screen; COLS*ROWS SHALL not exceed 4096-BASE.
REQ-004 clk_sys  in  1  system clock; all state on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 cpu_en  in  1  CPU owns RAM port this cycle.
REQ-007 cpu_we  in  1  CPU write strobe, qualified by cpu_en.
REQ-008 cpu_a  in  12  CPU address.
REQ-009 cpu_din  in  8  CPU write data.
REQ-010 cpu_dout  out  8  CPU read data.
REQ-011 cmd_valid  in  1  command request.
REQ-012 cmd_ready  out  1  high when command can be accepted.
REQ-013 cmd_op  in  2  00 CLEAR, 01 SCROLL_UP, 10 FILL_ROW, 11 reserved.
REQ-014 cmd_fill  in  8  fill byte.
REQ-015 cmd_row  in  4  target row for FILL_ROW.
REQ-016 busy  out  1  engine not idle.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 ram_a / ram_we / ram_d  out  12/1/8  video RAM port-A address, write enable, write data.
REQ-019 ram_q  in  8  port-A read data, valid the cycle after the address.

Function
REQ-020 States IDLE, RD, WR, FILL, DONE; cmd_ready = (state==IDLE); busy = (state!=IDLE).
REQ-021 Command accepted on cmd_valid&&cmd_ready; op, fill, row registered at acceptance; inputs ignored otherwise.
REQ-022 Arbitration: cpu_en has absolute priority; port drives cpu_a/cpu_we/cpu_din that cycle and the engine stalls, holding state and index.
REQ-023 Granted cycle = engine cycle with cpu_en low; only granted cycles advance the engine.
REQ-024 cpu_dout = ram_q combinationally.
REQ-025 CLEAR: FILL writes cmd_fill to BASE+i, i=0..COLS*ROWS-1, one per granted cycle, then DONE.
REQ-026 FILL_ROW: FILL writes BASE+row*COLS+i, i=0..COLS-1; row>=ROWS goes straight to DONE, no writes.
REQ-027 SCROLL_UP: for i=0..COLS*(ROWS-1)-1, granted RD reads BASE+i+COLS, granted WR writes captured byte to BASE+i; then FILL of last row with cmd_fill; then DONE.
REQ-028 Hold register loads ram_q unconditionally on the cycle after a granted RD, regardless of cpu_en.
REQ-029 DONE lasts one cycle, asserts done, returns to IDLE; back-to-back command accepted the following cycle.
REQ-030 Uncontended latency: CLEAR accepted cycle 0, writes cycles 1..COLS*ROWS, done at COLS*ROWS+1; SCROLL_UP done at 2*COLS*(ROWS-1)+COLS+1.
REQ-031 Reserved op: accepted, DONE next cycle, no RAM writes.
REQ-032 Engine ram_we low in IDLE, RD, DONE; address index arithmetic 12-bit, no wrap beyond BASE+COLS*ROWS-1.
REQ-033 CPU writes inside a region being scrolled are not coherent; CPU-written data may be overwritten by the engine.

Reset
REQ-034 rst low: state IDLE, index 0, hold 0, done 0, busy 0, engine write disabled; cmd_ready high after release.
REQ-035 Reset mid-operation aborts the command; no engine write occurs after reset assertion; no done pulse issued.
REQ-036 CPU mux path stays combinational during reset.

Structure
REQ-037 Package vga_ctrl_pkg holds op encodings, state encoding, default COLS/ROWS/BASE.
REQ-038 One sub-module vga_port_mux (combinational CPU/engine port select); FSM and counters in vga_blit_ctrl.

Verification
REQ-039 CLEAR fill=8'h20, no CPU traffic -> 512 writes of 8'h20 to 000..1FF, done at cycle 513, cmd_ready low throughout.
REQ-040 SCROLL_UP on row-indexed pattern (byte=row) -> rows 0..14 hold 1..15, row 15 holds cmd_fill, done at cycle 993.
REQ-041 SCROLL_UP with cpu_en asserted every third cycle -> identical final RAM image, CPU reads return correct data, completion delayed by stall count.
REQ-042 cpu_en asserted on cycle after every granted RD -> hold captures engine data, no corrupted copy.
REQ-043 FILL_ROW row=4'd5 fill=8'hAA -> 0A0..0BF = AA, all other bytes unchanged; done after 33 cycles.
REQ-044 rst low at write 100 of CLEAR -> no further writes, no done, busy 0, next command accepted after release.
